// File: rtl/uart_bus_bridge.sv
// UART command-frame bridge: parses W/R frames from the receiver, drives the core data bus,
// and returns 'K', four read bytes, or '?' to the transmitter.
//   state      | meaning
//   S_IDLE     | waiting for the command byte
//   S_ADDR     | collecting 4 address bytes
//   S_DATA     | collecting 4 write-data bytes
//   S_BUS_WR   | one-cycle bus write
//   S_BUS_RD   | one-cycle bus read, capture read_data
//   S_SEND     | hand next response byte to the UART when it is free
//   S_SEND_GAP | one cycle for the UART to raise busy
module uart_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_write,
  input  logic        tx_busy,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic [3:0]  write_mask,
  output logic        write_enable,
  output logic        read_enable,
  input  logic [31:0] read_data,
  output logic        active
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RESP_OK  = 8'h4B;
  localparam logic [7:0] RESP_BAD = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_SEND, S_SEND_GAP
  } state_t;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  rem_q, rem_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] shift_q, shift_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic        tx_write_c, we_c, re_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      shift_q    <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      shift_q    <= shift_d;
      tmr_q      <= tmr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    tmr_d      = tmr_q;
    tx_write_c = 1'b0;
    we_c       = 1'b0;
    re_c       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            is_wr_d    = (rx_data == CMD_WR);
            byte_cnt_d = 2'd0;
            tmr_d      = TMR_LOAD;
            state_d    = S_ADDR;
          end else begin
            shift_d = {RESP_BAD, 24'h0};
            rem_d   = 3'd1;
            state_d = S_SEND;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (rx_valid) begin
          if (state_q == S_ADDR) addr_d = {addr_q[23:0], rx_data};
          else                   wdata_d = {wdata_q[23:0], rx_data};
          tmr_d      = TMR_LOAD;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (state_q == S_DATA) state_d = S_BUS_WR;
            else                   state_d = is_wr_q ? S_DATA : S_BUS_RD;
          end
        end else if (tmr_q <= TW'(1)) begin
          // gap timer expired: drop the partial frame without any response
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_BUS_WR: begin
        we_c    = 1'b1;
        shift_d = {RESP_OK, 24'h0};
        rem_d   = 3'd1;
        state_d = S_SEND;
      end
      S_BUS_RD: begin
        re_c    = 1'b1;
        shift_d = read_data;
        rem_d   = 3'd4;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_write_c = 1'b1;
          shift_d    = {shift_q[23:0], 8'h00};
          rem_d      = rem_q - 3'd1;
          state_d    = S_SEND_GAP;
        end
      end
      S_SEND_GAP: begin
        state_d = (rem_q != 3'd0) ? S_SEND : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // strobes are qualified by rst so nothing fires during the reset cycle itself
  assign tx_write     = tx_write_c & rst;
  assign write_enable = we_c & rst;
  assign read_enable  = re_c & rst;
  assign write_mask   = {4{write_enable}};
  assign tx_data      = shift_q[31:24];
  assign address      = addr_q;
  assign write_data   = wdata_q;
  assign active       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: expected bus/UART events are queued when frames
// are issued; a negedge monitor pops and compares each strobe the DUT presents.
module tb_uart_bus_bridge;
  localparam int unsigned TMO = 16;
  localparam int EV_WR = 0;
  localparam int EV_RD = 1;
  localparam int EV_TX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic        tx_busy;
  logic [31:0] address, write_data, read_data;
  logic [3:0]  write_mask;
  logic        write_enable, read_enable, active;

  always #5 clk = ~clk;

  uart_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_write(tx_write), .tx_busy(tx_busy),
    .address(address), .write_data(write_data), .write_mask(write_mask),
    .write_enable(write_enable), .read_enable(read_enable),
    .read_data(read_data), .active(active)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h1234_5678;
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction
  assign read_data = mem_f(address);

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  int busy_len = 0;
  int busy_cnt = 0;
  bit tx_w_at_neg = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe kind=%0d addr=%h data=%h required=none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == EV_WR) begin
        check("wr_address", a, e.addr);
        check("wr_data", d, e.data);
      end else if (kind == EV_RD) begin
        check("rd_address", a, e.addr);
      end else begin
        check("tx_byte", 32'(d[7:0]), 32'(e.data[7:0]));
      end
    end
  endtask

  // monitor: sample mid-cycle, away from the rising edge
  always @(negedge clk) begin
    tx_w_at_neg = tx_write;
    if ((write_enable && read_enable) || (write_enable && tx_write) || (read_enable && tx_write)) begin
      checks++;
      errors++;
      $display("FAIL strobe_overlap we=%b re=%b tx=%b required=one", write_enable, read_enable, tx_write);
    end
    if (write_enable) begin
      check("wr_mask", 32'(write_mask), 32'hF);
      pop_check(EV_WR, address, write_data);
    end
    if (read_enable) pop_check(EV_RD, address, 32'h0);
    if (tx_write) begin
      check("tx_while_busy", 32'(tx_busy), 32'h0);
      pop_check(EV_TX, 32'h0, 32'(tx_data));
      tx_seen++;
    end
  end

  // UART transmitter model: busy starts the cycle after a strobe, lasts busy_len cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_w_at_neg) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt > 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 3; i >= 0; i--) begin
      idle($urandom_range(0, gap_max));
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic wait_done(input bit junk);
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!active) begin done = 1'b1; break; end
      if (junk && $urandom_range(0, 3) == 0) send_byte(8'($urandom));
      else idle(1);
    end
    check("frame_done_in_budget", 32'(done), 32'h1);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic run_frame(input int kind, input logic [31:0] a, input logic [31:0] d,
                           input logic [7:0] b, input bit junk);
    if (kind == 0) begin
      push_ev(EV_WR, a, d);
      push_ev(EV_TX, 32'h0, 32'h4B);
      send_byte(8'h57);
      check("active_after_cmd", 32'(active), 32'h1);
      send_word(a, 4);
      send_word(d, 4);
    end else if (kind == 1) begin
      push_ev(EV_RD, a, 32'h0);
      for (int i = 3; i >= 0; i--) push_ev(EV_TX, 32'h0, 32'(mem_f(a) >> (8*i)) & 32'hFF);
      send_byte(8'h52);
      check("active_after_cmd", 32'(active), 32'h1);
      send_word(a, 4);
    end else begin
      push_ev(EV_TX, 32'h0, 32'h3F);
      send_byte(b);
      check("active_after_cmd", 32'(active), 32'h1);
    end
    wait_done(junk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    check({tag, "_tx_write"}, 32'(tx_write), 32'h0);
    check({tag, "_address"}, address, 32'h0);
    check({tag, "_write_data"}, write_data, 32'h0);
    check({tag, "_write_mask"}, 32'(write_mask), 32'h0);
    check({tag, "_write_enable"}, 32'(write_enable), 32'h0);
    check({tag, "_read_enable"}, 32'(read_enable), 32'h0);
    check({tag, "_active"}, 32'(active), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_zero_outputs(tag);
    rst = 1'b1;
  endtask

  initial begin
    int base;
    bit got;
    logic [7:0] b;
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    idle(3);
    check_zero_outputs("reset");
    rst = 1'b1;
    idle(2);

    run_frame(0, 32'h1001_0100, 32'hDEAD_BEEF, 8'h00, 1'b0);
    run_frame(1, 32'h0000_0040, 32'h0, 8'h00, 1'b0);
    run_frame(2, 32'h0, 32'h0, 8'hAA, 1'b0);

    // partial write frame: last data byte never comes
    send_byte(8'h57);
    send_word(32'hCAFE_0000, 0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(8);
    check("timeout_still_active", 32'(active), 32'h1);
    idle(12);
    check("timeout_active_low", 32'(active), 32'h0);
    run_frame(1, 32'h0000_0040, 32'h0, 8'h00, 1'b0);

    busy_len = 50;
    base = tx_seen;
    run_frame(1, 32'h8000_1234, 32'h0, 8'h00, 1'b1);
    check("busy_tx_count", 32'(tx_seen - base), 32'h4);

    busy_len = 0;
    send_byte(8'h57);
    send_word(32'h0102_0304, 1);
    send_byte(8'hAB); send_byte(8'hCD);
    do_reset("rst_mid_data");
    idle(3);
    run_frame(1, 32'h0000_0040, 32'h0, 8'h00, 1'b0);

    busy_len = 50;
    base = tx_seen;
    push_ev(EV_RD, 32'h0000_0777, 32'h0);
    push_ev(EV_TX, 32'h0, 32'(mem_f(32'h0000_0777) >> 24));
    send_byte(8'h52);
    send_word(32'h0000_0777, 2);
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (tx_seen > base) begin got = 1'b1; break; end
      idle(1);
    end
    check("first_tx_before_reset", 32'(got), 32'h1);
    idle(5);
    do_reset("rst_mid_send");
    busy_len = 0;
    idle(60);
    check("no_late_strobe", 32'(tx_seen - base), 32'h1);
    run_frame(0, 32'h2000_0010, 32'h0BAD_F00D, 8'h00, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      busy_len = int'($urandom_range(0, 3));
      do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
      run_frame((r < 4) ? 0 : ((r < 8) ? 1 : 2), $urandom, $urandom, b, ($urandom_range(0, 1) == 1));
      idle(int'($urandom_range(0, 3)));
    end

    idle(5);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Host-side debug/load bridge: receives a byte stream from the UART receiver, parses simple command frames, and acts as an initiator on the core's data bus (the same address/write_data/write_mask/write_enable/read_data bus the core drives). Results go back to the host through the UART transmitter byte interface. The bridge lets a PC load programs, poke MMIO registers, and read back memory while the core is held via `active`.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: maximum idle gap between bytes inside a frame before the frame is aborted.
- `clk`  in  1  system clock; the block has one clock.
- `rst`  in  1  reset; reset is synchronous and active-low (0 = reset, sampled on `posedge clk`).
- `rx_data`  in  8  received byte from the UART receiver.
- `rx_valid`  in  1  one-cycle pulse: `rx_data` is valid.
- `tx_data`  out  8  byte to transmit.
- `tx_write`  out  1  one-cycle pulse: UART latches `tx_data` and starts sending.
- `tx_busy`  in  1  UART transmitter busy.
- `address`  out  32  bus address.
- `write_data`  out  32  bus write data.
- `write_mask`  out  4  byte enables; 4'b1111 during a write, 4'b0000 otherwise.
- `write_enable`  out  1  one-cycle bus write strobe.
- `read_enable`  out  1  one-cycle bus read strobe.
- `read_data`  in  32  bus read data, combinational from the address in the same cycle.
- `active`  out  1  high from the first byte of a frame until the response is fully handed to the UART; the integration uses it to stall the core and take the bus.

## Operation
- Frames, all multi-byte fields MSB first:
  - Write: 0x57 ('W'), 4 address bytes, 4 data bytes. Bus write with mask 4'b1111, then response 0x4B ('K').
  - Read: 0x52 ('R'), 4 address bytes. Bus read, then response of 4 bytes of `read_data`, MSB first.
  - Any other first byte: response 0x3F ('?'), no bus access.
- States: IDLE, ADDR, DATA, BUS_WR, BUS_RD, SEND, SEND_GAP.
  - IDLE: on `rx_valid`, 'W'/'R' -> ADDR (byte count 0), other -> SEND with 0x3F queued.
  - ADDR: shift byte into address register; after 4th byte, 'W' -> DATA, 'R' -> BUS_RD.
  - DATA: shift into data register; after 4th byte -> BUS_WR.
  - BUS_WR: `write_enable`=1, `write_mask`=4'b1111 for exactly one cycle; queue 0x4B; -> SEND.
  - BUS_RD: `read_enable`=1 for one cycle; capture `read_data` into the 32-bit response shift register at end of cycle; queue 4 bytes; -> SEND.
  - SEND: when `tx_busy`=0, pulse `tx_write` with the next byte; -> SEND_GAP.
  - SEND_GAP: one cycle, `tx_busy` ignored (UART raises busy one cycle after the strobe); then SEND if bytes remain, else IDLE.
- 2-bit byte counter for the ADDR/DATA fields; 3-bit remaining-byte counter for responses (1 or 4).
- `rx_valid` during BUS_WR, BUS_RD, SEND, or SEND_GAP: the byte is dropped.
- Timeout: a counter of width clog2(TIMEOUT_CYCLES+1) clears on each accepted byte in ADDR/DATA. On reaching TIMEOUT_CYCLES -> IDLE, no bus access, no response.

## Timing
- Reset: all outputs 0 (`tx_data`=0, `tx_write`=0, `address`=0, `write_data`=0, `write_mask`=0, `write_enable`=0, `read_enable`=0, `active`=0), state IDLE, counters 0. Reset mid-frame or mid-response aborts silently; no strobe is issued in or after the reset cycle.
- `active` goes high the cycle after the first `rx_valid` of a frame and low the cycle after the last SEND_GAP.
- Write: last data byte `rx_valid` in cycle N -> `write_enable` in N+1 with `address`/`write_data` stable -> `tx_write` (0x4B) in N+2 if `tx_busy`=0.
- Read: last address byte in cycle N -> `read_enable` in N+1, `read_data` sampled at end of N+1 -> first `tx_write` in N+2 if `tx_busy`=0; following bytes are at least 2 cycles apart and gated by `tx_busy`.
- `address` and `write_data` hold their last values outside strobes. Strobes are never asserted together.

## Test plan
- Write frame 57 10 01 01 00 DE AD BE EF, `tx_busy`=0 -> one `write_enable` with `address`=0x10010100, `write_data`=0xDEADBEEF, mask 4'b1111; then one `tx_write` with 0x4B.
- Read frame 52 00 00 00 40, bus returns 0x12345678 -> one `read_enable` at 0x00000040; `tx_write` bytes 12 34 56 78 in order.
- Unknown byte 0xAA -> single `tx_write` 0x3F, no bus strobes, back to IDLE.
- Write frame whose 4th data byte never arrives, with TIMEOUT_CYCLES=16 -> no strobes after 16 idle cycles, `active`=0; a following read frame works normally.
- Read with `tx_busy` held high for 50 cycles after each strobe -> exactly 4 `tx_write` pulses, each only when `tx_busy`=0; extra `rx_valid` bytes during SEND are dropped.
- `rst`=0 asserted mid-DATA and mid-SEND -> all outputs 0 next cycle, no late strobe; next frame is parsed from byte 0.
